lsdbuf_readout_seq: RTL

//  PL-side sequencer that drains the Simple-LSD line-segment buffer to a 64-bit valid/ready stream for DMA to PS.

---
 rtl/lsdbuf_readout_seq.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/lsdbuf_readout_seq.sv
// lsdbuf_readout_seq
//   Drains the Simple-LSD line-segment buffer into a 64-bit valid/ready stream.
//   A single start pulse freezes the buffer (write_protect), samples the line
//   count, reads every stored line, and sends each one as a single beat
//   {end_v, end_h, start_v, start_h} (16 b per field, zero-extended). The buffer
//   is then released.
// Ports
//   ps_clk, ps_rstn            clock, asynchronous active-low reset
//   start, abort               1-cycle control pulses from the PS register bank
//   out_lsdbuf_write_protect   freezes buffer writes while high
//   out_lsdbuf_raddr           buffer read address
//   in_lsdbuf_line_num/ready   stored line count / buffer holds a full frame
//   in_lsdbuf_start_*/end_*    line endpoints at raddr, RD_LAT cycles after raddr
//   m_tdata/m_tvalid/m_tlast   output stream, m_tready its back-pressure
//   busy, done, err            status level and 1-cycle completion/error pulses
//   lines_sent                 beats accepted in the current or last run
module lsdbuf_readout_seq #(
    parameter int unsigned H_FRAME     = 640,
    parameter int unsigned V_FRAME     = 480,
    parameter int unsigned LSD_BUFSIZE = 2048,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned TIMEOUT     = 1024,
    localparam int unsigned HW = $clog2(H_FRAME),
    localparam int unsigned VW = $clog2(V_FRAME),
    localparam int unsigned AW = $clog2(LSD_BUFSIZE)
) (
    input  logic          ps_clk,
    input  logic          ps_rstn,
    input  logic          start,
    input  logic          abort,
    output logic          out_lsdbuf_write_protect,
    output logic [AW-1:0] out_lsdbuf_raddr,
    input  logic [AW-1:0] in_lsdbuf_line_num,
    input  logic          in_lsdbuf_ready,
    input  logic [HW-1:0] in_lsdbuf_start_h,
    input  logic [HW-1:0] in_lsdbuf_end_h,
    input  logic [VW-1:0] in_lsdbuf_start_v,
    input  logic [VW-1:0] in_lsdbuf_end_v,
    output logic [63:0]   m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] lines_sent
);

    // One shared wait counter covers the timeout, settle and read-latency waits.
    localparam int unsigned CW = $clog2(TIMEOUT + SETTLE + RD_LAT + 1);

    typedef enum logic [2:0] {
        StIdle, StWaitRdy, StProtect, StAddr, StRead, StPush, StRelease
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   num_q, num_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic            protect_q, protect_d;
    logic [63:0]     tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [AW-1:0]   sent_q, sent_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        raddr_d   = raddr_q;
        protect_d = protect_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        sent_d    = sent_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWaitRdy;
                    busy_d  = 1'b1;
                    sent_d  = '0;
                    cnt_d   = '0;
                end
            end
            StWaitRdy: begin
                if (in_lsdbuf_ready) begin
                    state_d   = StProtect;
                    protect_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StProtect: begin
                // Line count is sampled exactly once per run, SETTLE cycles after protect rose.
                if (cnt_q == CW'(SETTLE)) begin
                    num_d = in_lsdbuf_line_num;
                    if (in_lsdbuf_line_num == '0) begin
                        state_d   = StRelease;
                        protect_d = 1'b0;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        state_d = StAddr;
                        raddr_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StAddr: begin
                state_d = StRead;
                cnt_d   = '0;
            end
            StRead: begin
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    state_d  = StPush;
                    tdata_d  = {16'(in_lsdbuf_end_v), 16'(in_lsdbuf_end_h),
                                16'(in_lsdbuf_start_v), 16'(in_lsdbuf_start_h)};
                    tvalid_d = 1'b1;
                    tlast_d  = (raddr_q == num_q - AW'(1));
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StPush: begin
                if (m_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    sent_d   = sent_q + AW'(1);
                    if (tlast_q) begin
                        state_d   = StRelease;
                        protect_d = 1'b0;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        state_d = StAddr;
                        raddr_d = raddr_q + AW'(1);
                    end
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything outside IDLE; a beat accepted on the same edge still counts.
        if (abort && (state_q != StIdle)) begin
            state_d   = StIdle;
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            protect_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge ps_clk or negedge ps_rstn) begin
        if (!ps_rstn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            num_q     <= '0;
            raddr_q   <= '0;
            protect_q <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            raddr_q   <= raddr_d;
            protect_q <= protect_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sent_q    <= sent_d;
        end
    end

    assign out_lsdbuf_write_protect = protect_q;
    assign out_lsdbuf_raddr         = raddr_q;
    assign m_tdata                  = tdata_q;
    assign m_tvalid                 = tvalid_q;
    assign m_tlast                  = tlast_q;
    assign busy                     = busy_q;
    assign done                     = done_q;
    assign err                      = err_q;
    assign lines_sent               = sent_q;

endmodule
